// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Holds the scan FSM state encoding and the blank code for the decoder.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SHOW,
        ST_DEAD
    } scan_state_t;

    localparam logic [3:0] SEG_BLANK_CODE = 4'hF;

endpackage

// File: rtl/seg_scan_ctrl_scan_timer.sv
// scan_timer: one counter covering a whole digit slot (lit + dead time).
// Ports: clk, rst_n (async low), clr -> show_done, dead_done.
module scan_timer #(
    parameter int DIV  = 50000,
    parameter int DEAD = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic show_done,
    output logic dead_done
);

    // Counts 0..DIV+DEAD-1: the lit part ends at DIV-1, the slot at LAST.
    // With DEAD=0 both strobes coincide.
    localparam int LAST = DIV + DEAD - 1;
    localparam int CW   = $clog2(LAST + 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == CW'(LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign show_done = (cnt == CW'(DIV - 1));
    assign dead_done = (cnt == CW'(LAST));

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed N-digit 7-segment scan with dead time, blink, LZ blank.
// In: en, wr_en/wr_addr/wr_data, blink_mask, lz_blank. Out: data_out, dig_n, frame_done.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int N_DIG        = 4,
    parameter int DIV          = 50000,
    parameter int DEAD         = 16,
    parameter int BLINK_FRAMES = 64,
    parameter int AW           = $clog2(N_DIG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [3:0]       wr_data,
    input  logic [N_DIG-1:0] blink_mask,
    input  logic             lz_blank,
    output logic [3:0]       data_out,
    output logic [N_DIG-1:0] dig_n,
    output logic             frame_done
);

    localparam int FW = $clog2(2 * BLINK_FRAMES);

    scan_state_t      state, state_nxt;
    logic [AW-1:0]    idx, idx_nxt;
    logic [FW-1:0]    fcnt, fcnt_nxt;
    logic [3:0]       digs [N_DIG];
    logic             show_done, dead_done;
    logic             wrap, last_idx;
    logic             upper_zero, lz_hit, blink_bit, blink_off;
    logic [3:0]       code, data_nxt;
    logic [N_DIG-1:0] dig_n_nxt;

    scan_timer #(
        .DIV  (DIV),
        .DEAD (DEAD)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (!en || state == ST_OFF),
        .show_done (show_done),
        .dead_done (dead_done)
    );

    // Out-of-range addresses match no register and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIG; i++) digs[i] <= 4'h0;
        end else if (wr_en) begin
            for (int i = 0; i < N_DIG; i++) begin
                if (wr_addr == AW'(i)) digs[i] <= wr_data;
            end
        end
    end

    assign last_idx = (idx == AW'(N_DIG - 1));

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wrap      = 1'b0;
        if (!en) begin
            state_nxt = ST_OFF;
            idx_nxt   = '0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    state_nxt = ST_SHOW;
                    idx_nxt   = '0;
                end
                ST_SHOW: begin
                    if (show_done) begin
                        if (DEAD == 0) begin
                            idx_nxt = last_idx ? '0 : idx + AW'(1);
                            wrap    = last_idx;
                        end else begin
                            state_nxt = ST_DEAD;
                        end
                    end
                end
                ST_DEAD: begin
                    if (dead_done) begin
                        state_nxt = ST_SHOW;
                        idx_nxt   = last_idx ? '0 : idx + AW'(1);
                        wrap      = last_idx;
                    end
                end
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    always_comb begin
        fcnt_nxt = fcnt;
        if (wrap) begin
            fcnt_nxt = (fcnt == FW'(2 * BLINK_FRAMES - 1)) ? '0 : fcnt + FW'(1);
        end
    end

    // Output is computed for the digit being selected, so the blink phase
    // must be that of the frame being entered.
    assign blink_off = (fcnt_nxt >= FW'(BLINK_FRAMES));

    // Scan from the top digit down; upper_zero covers digits i..N_DIG-1.
    always_comb begin
        upper_zero = 1'b1;
        lz_hit     = 1'b0;
        code       = 4'h0;
        blink_bit  = 1'b0;
        for (int i = N_DIG - 1; i >= 0; i--) begin
            if (digs[i] != 4'h0) upper_zero = 1'b0;
            if (idx_nxt == AW'(i)) begin
                code      = digs[i];
                blink_bit = blink_mask[i];
                lz_hit    = (i != 0) && upper_zero;
            end
        end
    end

    always_comb begin
        dig_n_nxt = '1;
        data_nxt  = SEG_BLANK_CODE;
        if (state_nxt == ST_SHOW) begin
            for (int i = 0; i < N_DIG; i++) begin
                dig_n_nxt[i] = (idx_nxt != AW'(i));
            end
            if (blink_bit && blink_off) begin
                data_nxt = SEG_BLANK_CODE;
            end else if (lz_blank && lz_hit) begin
                data_nxt = SEG_BLANK_CODE;
            end else begin
                data_nxt = code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_OFF;
            idx        <= '0;
            fcnt       <= '0;
            dig_n      <= '1;
            data_out   <= SEG_BLANK_CODE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            fcnt       <= fcnt_nxt;
            dig_n      <= dig_n_nxt;
            data_out   <= data_nxt;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (N_DIG=4, DIV=4, DEAD=1, BLINK_FRAMES=2).
// A second 3-digit instance covers the out-of-range write address.
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       en3;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] blink_mask;
    logic       lz_blank;
    logic [3:0] data_out;
    logic [3:0] dig_n;
    logic       frame_done;
    logic [3:0] data3;
    logic [2:0] dig_n3;
    logic       fd3;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] dig_n;
        logic [3:0] data;
        logic       fd;
    } vec_t;

    vec_t tbl [40];

    seg_scan_ctrl #(
        .N_DIG(4), .DIV(4), .DEAD(1), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .blink_mask(blink_mask), .lz_blank(lz_blank),
        .data_out(data_out), .dig_n(dig_n), .frame_done(frame_done)
    );

    seg_scan_ctrl #(
        .N_DIG(3), .DIV(4), .DEAD(1), .BLINK_FRAMES(2)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .blink_mask(blink_mask[2:0]), .lz_blank(lz_blank),
        .data_out(data3), .dig_n(dig_n3), .frame_done(fd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_dark(input string nm);
        chk({nm, "_dign"}, dig_n, 4'b1111);
        chk({nm, "_data"}, data_out, 4'hF);
        chk({nm, "_fd"}, frame_done, 1'b0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Asynchronous reset pulse; outputs are checked before any clock edge.
    task automatic do_reset(input string nm);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        en3   = 1'b0;
        #1;
        chk_dark(nm);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Starts at the first SHOW cycle of digit 0; ends 20 cycles later.
    task automatic scan_frame(input string nm, input logic [3:0] c0,
                              input logic [3:0] c1, input logic [3:0] c2,
                              input logic [3:0] c3);
        logic [3:0] c [4];
        logic [3:0] dn;
        c = '{c0, c1, c2, c3};
        for (int d = 0; d < 4; d++) begin
            dn = ~(4'b0001 << d);
            chk({nm, "_dign"}, dig_n, dn);
            chk({nm, "_data"}, data_out, c[d]);
            repeat (5) @(negedge clk);
        end
    endtask

    initial begin
        logic [2:0] dn3;
        rst_n      = 1'b0;
        en         = 1'b0;
        en3        = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = 2'd0;
        wr_data    = 4'd0;
        blink_mask = 4'b0000;
        lz_blank   = 1'b0;

        for (int f = 0; f < 2; f++) begin
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 5; c++) begin
                    if (c < 4) begin
                        tbl[f*20 + d*5 + c].dig_n = ~(4'b0001 << d);
                        tbl[f*20 + d*5 + c].data  = 4'(d + 1);
                    end else begin
                        tbl[f*20 + d*5 + c].dig_n = 4'b1111;
                        tbl[f*20 + d*5 + c].data  = 4'hF;
                    end
                    tbl[f*20 + d*5 + c].fd = (f == 1 && d == 0 && c == 0);
                end
            end
        end

        repeat (2) @(negedge clk);
        chk_dark("reset");
        chk("reset_dign3", dig_n3, 3'b111);
        rst_n = 1'b1;
        @(negedge clk);

        wr(2'd0, 4'd1);
        wr(2'd1, 4'd2);
        wr(2'd2, 4'd3);
        wr(2'd3, 4'd4);

        // 3-digit build: the address-3 write must not land anywhere.
        en3 = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            dn3 = ~(3'b001 << (d % 3));
            chk("w3_dign", dig_n3, dn3);
            chk("w3_data", data3, 4'((d % 3) + 1));
            chk("w3_fd", fd3, d == 3);
            repeat (5) @(negedge clk);
        end
        en3 = 1'b0;
        chk_dark("idle_main");

        en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            chk("scan_dign", dig_n, tbl[i].dig_n);
            chk("scan_data", data_out, tbl[i].data);
            chk("scan_fd", frame_done, tbl[i].fd);
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
        chk_dark("scan_off");

        do_reset("rst_lz");
        wr(2'd2, 4'd7);
        lz_blank = 1'b1;
        en = 1'b1;
        @(negedge clk);
        scan_frame("lz_on", 4'd0, 4'd0, 4'd7, 4'hF);
        lz_blank = 1'b0;
        scan_frame("lz_off", 4'd0, 4'd0, 4'd7, 4'd0);
        en = 1'b0;
        @(negedge clk);
        wr(2'd2, 4'd0);
        lz_blank = 1'b1;
        en = 1'b1;
        @(negedge clk);
        scan_frame("lz_all0", 4'd0, 4'hF, 4'hF, 4'hF);
        en = 1'b0;
        lz_blank = 1'b0;
        @(negedge clk);

        do_reset("rst_blink");
        wr(2'd0, 4'd5);
        wr(2'd1, 4'd6);
        wr(2'd2, 4'd7);
        wr(2'd3, 4'd8);
        blink_mask = 4'b0001;
        en = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 5; f++) begin
            scan_frame("blink", (f == 2 || f == 3) ? 4'hF : 4'd5,
                       4'd6, 4'd7, 4'd8);
        end
        en = 1'b0;
        blink_mask = 4'b0000;
        @(negedge clk);

        // Drop en in the middle of digit 2.
        en = 1'b1;
        @(negedge clk);
        repeat (11) @(negedge clk);
        chk("drop_pre_dign", dig_n, 4'b1011);
        chk("drop_pre_data", data_out, 4'd7);
        en = 1'b0;
        @(negedge clk);
        chk_dark("drop1");
        @(negedge clk);
        chk_dark("drop2");
        en = 1'b1;
        @(negedge clk);
        chk("restart_dign", dig_n, 4'b1110);
        chk("restart_data", data_out, 4'd5);
        chk("restart_fd", frame_done, 1'b0);

        // Write to the lit digit: visible one cycle after the write edge.
        repeat (10) @(negedge clk);
        chk("wlit_pre", data_out, 4'd7);
        wr_en   = 1'b1;
        wr_addr = 2'd2;
        wr_data = 4'd9;
        @(negedge clk);
        wr_en = 1'b0;
        chk("wlit_old", data_out, 4'd7);
        @(negedge clk);
        chk("wlit_new", data_out, 4'd9);
        chk("wlit_dign", dig_n, 4'b1011);

        // Write landing on the digit switch edge.
        repeat (2) @(negedge clk);
        chk("wsw_dead_dign", dig_n, 4'b1111);
        chk("wsw_dead_data", data_out, 4'hF);
        wr_en   = 1'b1;
        wr_addr = 2'd3;
        wr_data = 4'd2;
        @(negedge clk);
        wr_en = 1'b0;
        chk("wsw_dign", dig_n, 4'b0111);
        chk("wsw_old", data_out, 4'd8);
        @(negedge clk);
        chk("wsw_new", data_out, 4'd2);

        // Reset while frame_done is high.
        repeat (4) @(negedge clk);
        chk("rst_mid_fd_pre", frame_done, 1'b1);
        chk("rst_mid_dign_pre", dig_n, 4'b1110);
        do_reset("rst_mid");
        en = 1'b1;
        @(negedge clk);
        scan_frame("rst_zero", 4'd0, 4'd0, 4'd0, 4'd0);
        en = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
